// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: instruction field layout,
// datapath width, default reset PC, fetch FSM states and the prefetch entry format.
package instr_fetch_unit_pkg;

  localparam int XLEN = 16;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;

  // Instruction field positions: {opcode, rs, rt, rd, funct}, or imm in the low byte
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 14;
  localparam int RS_MSB    = 13;
  localparam int RS_LSB    = 11;
  localparam int RT_MSB    = 10;
  localparam int RT_LSB    = 8;
  localparam int RD_MSB    = 7;
  localparam int RD_LSB    = 5;
  localparam int FUNCT_MSB = 4;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] instr_opcode(input logic [XLEN-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch buffer of {pc, instr} entries. Flush empties the buffer and wins over a
// same-cycle push; the head reads as zero while the buffer is empty.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head_entry,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  // A push into a full buffer is only legal when the head leaves in the same cycle
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_reg] <= push_entry;
  end

  assign head_entry = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter and fetch sequencer: one outstanding req/ack fetch at a time,
// results queued in a prefetch buffer, redirects flush the buffer and drop in-flight data.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_INC   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [15:0] PC_STEP = 16'(PC_INC);

  fetch_state_t  state_reg, state_next;
  logic [15:0]   fetch_pc_reg, fetch_pc_next;
  logic [15:0]   addr_reg, addr_next;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after_push;
  fetch_entry_t  head_entry;
  fetch_entry_t  push_entry;

  assign pop  = instr_valid && instr_ready;
  assign push = (state_reg == WAIT) && imem_ack && !redirect_valid;
  // Occupancy once this cycle's response lands, used for back-to-back issue
  assign count_after_push = fifo_count + CW'(1) - CW'(pop);
  assign push_entry = '{pc: fetch_pc_reg, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      addr_reg     <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    addr_next     = addr_reg;
    case (state_reg)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
        end else if (fetch_en && (!fifo_full || pop)) begin
          state_next = WAIT;
          addr_next  = fetch_pc_reg;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          state_next    = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc_reg + PC_STEP;
          if (fetch_en && (count_after_push < CW'(DEPTH))) begin
            addr_next = fetch_pc_reg + PC_STEP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        // Address stays on the abandoned fetch until memory acknowledges it
        if (redirect_valid) fetch_pc_next = redirect_pc;
        if (imem_ack)       state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_entry (head_entry),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign imem_req    = (state_reg != IDLE);
  assign imem_addr   = addr_reg;
  assign instr_valid = !fifo_empty;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model returns addr^C3C3 after a
// programmable number of request cycles; outputs are sampled 1ns after the rising edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int ack_cnt = 0;
  logic [15:0] cons_q[$];

  typedef struct {
    logic        fetch_en;
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DEPTH   (2),
    .RESET_PC(16'h0000),
    .PC_INC  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  // Memory model: ack after ack_delay idle request cycles, data = addr ^ C3C3
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_ack   = 1'b0;
      imem_rdata = 16'h0000;
      wait_cnt   = 0;
    end else if (!imem_req) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      if (imem_ack) wait_cnt = 0;
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ 16'hC3C3;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ack) begin
        ack_cnt++;
        $display("fetch  addr=%h data=%h", imem_addr, imem_rdata);
      end
      if (instr_valid && instr_ready) begin
        cons_q.push_back(instr_pc);
        $display("issue  pc=%h instr=%h", instr_pc, instr);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic fe, input logic rdy);
    rst_n          = 1'b0;
    fetch_en       = fe;
    instr_ready    = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    ack_delay      = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cons_q.delete();
    ack_cnt = 0;
  endtask

  initial begin
    int n;
    logic found;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hC3C3};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'hC3C1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'hC3C7};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0006, 16'hC3C5};

    // Reset values and steady-state streaming
    do_reset(1'b1, 1'b1);
    check("rst_req",   {15'b0, imem_req},    16'h0000);
    check("rst_addr",  imem_addr,            16'h0000);
    check("rst_valid", {15'b0, instr_valid}, 16'h0000);
    check("rst_instr", instr,                16'h0000);
    check("rst_pc",    instr_pc,             16'h0000);
    for (int i = 0; i < 5; i++) begin
      fetch_en    = vecs[i].fetch_en;
      instr_ready = vecs[i].ready;
      tick();
      check($sformatf("v%0d_req", i),   {15'b0, imem_req},    {15'b0, vecs[i].req});
      check($sformatf("v%0d_addr", i),  imem_addr,            vecs[i].addr);
      check($sformatf("v%0d_valid", i), {15'b0, instr_valid}, {15'b0, vecs[i].valid});
      check($sformatf("v%0d_pc", i),    instr_pc,             vecs[i].pc);
      check($sformatf("v%0d_instr", i), instr,                vecs[i].instr);
    end

    // Datapath stall fills the buffer, then fetching resumes
    do_reset(1'b1, 1'b0);
    repeat (6) tick();
    check("stall_req",   {15'b0, imem_req},    16'h0000);
    check("stall_acks",  16'(ack_cnt),         16'd2);
    check("stall_valid", {15'b0, instr_valid}, 16'h0001);
    check("stall_pc",    instr_pc,             16'h0000);
    check("stall_instr", instr,                16'hC3C3);
    instr_ready = 1'b1;
    tick();
    check("resume_pc",   instr_pc,             16'h0002);
    check("resume_req",  {15'b0, imem_req},    16'h0001);
    check("resume_addr", imem_addr,            16'h0004);
    tick();
    check("resume_pc2",  instr_pc,             16'h0004);
    check("resume_first", cons_q[0],           16'h0000);

    // Redirect while the fetch of 0006 is stalled in memory
    do_reset(1'b1, 1'b1);
    repeat (4) tick();
    check("t3_addr0006", imem_addr, 16'h0006);
    ack_delay      = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    check("t3_dis_req",   {15'b0, imem_req},    16'h0001);
    check("t3_dis_addr",  imem_addr,            16'h0006);
    check("t3_flush",     {15'b0, instr_valid}, 16'h0000);
    repeat (2) tick();
    check("t3_hold_addr", imem_addr,            16'h0006);
    tick();
    ack_delay = 0;
    check("t3_idle_req",  {15'b0, imem_req},    16'h0000);
    check("t3_idle_vld",  {15'b0, instr_valid}, 16'h0000);
    tick();
    check("t3_new_req",   {15'b0, imem_req},    16'h0001);
    check("t3_new_addr",  imem_addr,            16'h0040);
    tick();
    check("t3_pc",        instr_pc,             16'h0040);
    check("t3_instr",     instr,                16'hC383);
    found = 1'b0;
    foreach (cons_q[k]) if (cons_q[k] == 16'h0006) found = 1'b1;
    check("t3_no_0006",   {15'b0, found},       16'h0000);

    // Redirect coincident with the ack of 0008
    do_reset(1'b1, 1'b1);
    repeat (5) tick();
    check("t4_addr0008", imem_addr, 16'h0008);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    check("t4_req_drop", {15'b0, imem_req},    16'h0000);
    check("t4_flush",    {15'b0, instr_valid}, 16'h0000);
    check("t4_last_pop", cons_q[$],            16'h0006);
    tick();
    check("t4_req",      {15'b0, imem_req},    16'h0001);
    check("t4_addr",     imem_addr,            16'h0100);
    tick();
    check("t4_pc",       instr_pc,             16'h0100);
    check("t4_instr",    instr,                16'hC2C3);

    // Two redirects during one discard: the later target wins
    do_reset(1'b1, 1'b1);
    repeat (2) tick();
    check("t5_addr0002", imem_addr, 16'h0002);
    ack_delay      = 4;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0020;
    tick();
    redirect_valid = 1'b0;
    check("t5_dis_addr", imem_addr,            16'h0002);
    check("t5_flush",    {15'b0, instr_valid}, 16'h0000);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    tick();
    redirect_valid = 1'b0;
    check("t5_hold",     imem_addr,            16'h0002);
    ack_delay = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(imem_req && imem_addr != 16'h0002) && n < 10);
    check("t5_req_seen", {15'b0, (n < 10)},    16'h0001);
    check("t5_addr",     imem_addr,            16'h0080);
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < 10);
    check("t5_pc",       instr_pc,             16'h0080);

    // PC wrap at FFFE and reset during an outstanding fetch
    do_reset(1'b0, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick();
    check("t6_no_issue", {15'b0, imem_req},    16'h0000);
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    tick();
    check("t6_addrFFFE", imem_addr,            16'hFFFE);
    tick();
    check("t6_wrap",     imem_addr,            16'h0000);
    check("t6_pc",       instr_pc,             16'hFFFE);
    check("t6_instr",    instr,                16'h3C3D);
    ack_delay = 5;
    tick();
    check("t6_wait_req", {15'b0, imem_req},    16'h0001);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req",  {15'b0, imem_req},    16'h0000);
    check("t6_rst_vld",  {15'b0, instr_valid}, 16'h0000);
    check("t6_rst_pc",   instr_pc,             16'h0000);
    @(negedge clk);
    ack_delay = 0;
    rst_n     = 1'b1;
    tick();
    check("t6_refetch",  imem_addr,            16'h0000);
    check("t6_ref_req",  {15'b0, imem_req},    16'h0001);
    tick();
    check("t6_ref_pc",   instr_pc,             16'h0000);
    check("t6_ref_vld",  {15'b0, instr_valid}, 16'h0001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
